// File: rtl/fpmult_pack_round.sv
// fpmult_pack_round: two-stage back end of the 8-bit FP multiplier (1/3/4, bias 3).
// Stage 1 normalizes the raw significand product. Stage 2 rounds, range-checks,
// resolves exceptions and packs the result word. Both stages use a valid/ready handshake.
// Build option: define FPMULT_ROUND_EN for round-to-nearest-even.
// Without it the block truncates. inexact is still reported, and the range checks
// use the unrounded exponent.
module fpmult_pack_round (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_sign,
   input  logic [5:0] in_exp,
   input  logic [9:0] in_mant,
   input  logic [4:0] in_exc,
   input  logic       in_zero,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_result,
   output logic [3:0] out_flags
);

   localparam int STAGES = 2;

   // in_exc bit positions
   localparam int EXC_ANY  = 4;
   localparam int EXC_ANAN = 3;
   localparam int EXC_BNAN = 2;
   localparam int EXC_AINF = 1;
   localparam int EXC_BINF = 0;

   localparam logic [7:0] QNAN = 8'h78;

   // normalized operand held between the stages
   typedef struct packed {
      logic       sign;
      logic [6:0] exp;     // signed two's complement
      logic [3:0] frac;
      logic       guard;
      logic       sticky;
      logic [4:0] exc;
      logic       zero;
   } norm_t;

   // packed result word and its per-beat flags
   typedef struct packed {
      logic [7:0] result;
      logic [3:0] flags;   // {invalid, overflow, underflow, inexact}
   } res_t;

   logic [STAGES:1] vld_pipe;
   logic            adv1, adv2;
   norm_t           norm_d, norm_q;
   res_t            res_d, res_q;

   // stage 2 working values
   logic       rnd_inc;
   logic [4:0] frac_sum;
   logic [3:0] frac_rnd;
   logic [6:0] exp_rnd;
   logic       inexact;
   logic       exc_nan, exc_inf, inf_zero;
   logic       ovf, unf;

   // A stage loads when it is empty or when the stage downstream of it is draining.
   assign adv2     = !vld_pipe[2] | out_ready;
   assign adv1     = !vld_pipe[1] | adv2;
   assign in_ready = adv1;

   assign out_valid  = vld_pipe[2];
   assign out_result = res_q.result;
   assign out_flags  = res_q.flags;

   // Normalize: a product of 2.0 or more shifts right one place and bumps the exponent.
   always_comb begin
      norm_d      = '0;
      norm_d.sign = in_sign;
      norm_d.exc  = in_exc;
      norm_d.zero = in_zero;
      if (in_mant[9]) begin
         norm_d.exp    = {in_exp[5], in_exp} + 7'd1;
         norm_d.frac   = in_mant[8:5];
         norm_d.guard  = in_mant[4];
         norm_d.sticky = |in_mant[3:0];
      end else begin
         norm_d.exp    = {in_exp[5], in_exp};
         norm_d.frac   = in_mant[7:4];
         norm_d.guard  = in_mant[3];
         norm_d.sticky = |in_mant[2:0];
      end
   end

   // Rounding increment. In a truncating build it is tied off, so no mantissa carry can occur.
`ifdef FPMULT_ROUND_EN
   assign rnd_inc = norm_q.guard & (norm_q.sticky | norm_q.frac[0]);
`else
   assign rnd_inc = 1'b0;
`endif

   // Round: a carry out of the 4-bit fraction wraps it to zero and bumps the exponent.
   always_comb begin
      frac_sum = {1'b0, norm_q.frac} + {4'b0000, rnd_inc};
      frac_rnd = frac_sum[4] ? 4'b0000 : frac_sum[3:0];
      exp_rnd  = norm_q.exp + {6'b000000, frac_sum[4]};
      inexact  = norm_q.guard | norm_q.sticky;
      ovf      = $signed(exp_rnd) >= 7'sd7;
      unf      = $signed(exp_rnd) <= 7'sd0;
   end

   // Exception decode. The summary bit gates the detail bits, so an all-clear
   // vector always takes the normal path.
   always_comb begin
      exc_nan  = norm_q.exc[EXC_ANY] & (norm_q.exc[EXC_ANAN] | norm_q.exc[EXC_BNAN]);
      exc_inf  = norm_q.exc[EXC_ANY] & (norm_q.exc[EXC_AINF] | norm_q.exc[EXC_BINF]);
      inf_zero = exc_inf & norm_q.zero;
   end

   // Result select in priority order: NaN or inf*0, then inf, then zero,
   // then overflow, then underflow, then normal.
   always_comb begin
      res_d = '0;
      if (exc_nan | inf_zero) begin
         res_d.result = QNAN;
         res_d.flags  = {inf_zero, 3'b000};
      end else if (exc_inf) begin
         res_d.result = {norm_q.sign, 3'b111, 4'b0000};
      end else if (norm_q.zero) begin
         res_d.result = {norm_q.sign, 7'b0000000};
      end else if (ovf) begin
         res_d.result = {norm_q.sign, 3'b111, 4'b0000};
         res_d.flags  = 4'b0101;
      end else if (unf) begin
         res_d.result = {norm_q.sign, 7'b0000000};
         res_d.flags  = 4'b0011;
      end else begin
         res_d.result = {norm_q.sign, exp_rnd[2:0], frac_rnd};
         res_d.flags  = {3'b000, inexact};
      end
   end

   // Pipeline registers. Each stage captures when its advance enable is high;
   // otherwise it holds, which keeps the output stable under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         norm_q   <= '0;
         res_q    <= '0;
      end else begin
         if (adv1) begin
            vld_pipe[1] <= in_valid;
            norm_q      <= norm_d;
         end
         if (adv2) begin
            vld_pipe[2] <= vld_pipe[1];
            res_q       <= res_d;
         end
      end
   end

endmodule
